// File: rtl/data_mem_if.sv
// Bus between the MEM-stage controls and the data-memory access unit.
//   master (pipeline side): drives Memtoreg, Memwrite, Mode, Signext2,
//                           addr, wdata; observes rdata, stall, misalign.
//   slave  (memory unit)  : the opposite directions.
// Handshake: a request is presented by raising Memtoreg and/or Memwrite with
// the address, size and data.  While stall is 1 the master holds every
// request signal stable.  The request is complete on the first rising edge
// at which stall is 0.  rdata is valid for a load from that cycle on and
// holds until the next completed load.
interface data_mem_if;
  logic        Memtoreg;
  logic        Memwrite;
  logic [1:0]  Mode;
  logic        Signext2;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;

  modport master (
    output Memtoreg, Memwrite, Mode, Signext2, addr, wdata,
    input  rdata, stall, misalign
  );

  modport slave (
    input  Memtoreg, Memwrite, Mode, Signext2, addr, wdata,
    output rdata, stall, misalign
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory access unit for the MEM stage.  It performs word, halfword and
// byte loads and stores against an internal 32-bit synchronous RAM.
// Sub-word stores are done as read-modify-write.
//   clk, rst  : clock; asynchronous active-high reset
//   bus       : data_mem_if.slave (request controls, rdata, stall, misalign)
//   dbg_state : current FSM state (0 = IDLE, 1 = RD_WAIT, 2 = DONE)
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus,
  output logic [1:0] dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic [31:0] rdata_q;

  // Request decode
  logic [ADDR_WIDTH-1:0] idx;
  logic req_active, req_load, is_word, is_half, bad_align;

  assign idx        = bus.addr[ADDR_WIDTH+1:2];
  // Reset masks requests so that nothing is started and stall stays low
  // while rst is held, even if the pipeline still presents a request.
  assign req_active = (bus.Memtoreg | bus.Memwrite) & ~rst;
  assign req_load   = bus.Memtoreg;                 // load wins over store
  assign is_word    = bus.Mode[1];                  // 10 and 11 are word
  assign is_half    = (bus.Mode == 2'b01);
  assign bad_align  = (is_half & bus.addr[0]) | (is_word & (bus.addr[1:0] != 2'b00));

  // Latched request used in RD_WAIT
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [1:0]            lat_off;
  logic [1:0]            lat_mode;
  logic                  lat_sext;
  logic                  lat_load;
  logic [31:0]           lat_wdata;

  logic stall_c, start, word_we;

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    start     = 1'b0;
    word_we   = 1'b0;
    case (state)
      IDLE: begin
        if (req_active && !bad_align) begin
          if (!req_load && is_word) begin
            word_we = 1'b1;
          end else begin
            start     = 1'b1;
            stall_c   = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall_c   = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.stall    = stall_c;
  assign bus.misalign = (state == IDLE) && (bus.Memtoreg || bus.Memwrite) && bad_align;
  assign bus.rdata    = rdata_q;
  assign dbg_state    = state;

  // Lane extraction and extension of the word read in RD_WAIT
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;

  always_comb begin
    byte_v = rd_word[{lat_off, 3'b000} +: 8];
    half_v = lat_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (lat_mode)
      2'b00:   load_val = {{24{lat_sext & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{lat_sext & half_v[15]}}, half_v};
      default: load_val = rd_word;
    endcase
  end

  // Merge of the store byte/half into the word read back
  logic [31:0] merged;

  always_comb begin
    merged = rd_word;
    if (lat_mode == 2'b00) begin
      merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    end else if (lat_off[1]) begin
      merged[31:16] = lat_wdata[15:0];
    end else begin
      merged[15:0] = lat_wdata[15:0];
    end
  end

  // FSM state and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == RD_WAIT && lat_load) rdata_q <= load_val;
    end
  end

  // RAM and request latches; not reset.  The merge write is keyed on
  // RD_WAIT, which reset leaves asynchronously, so a reset in RD_WAIT
  // drops the pending write.
  always_ff @(posedge clk) begin
    if (word_we) mem[idx] <= bus.wdata;
    if (state == RD_WAIT && !lat_load) mem[lat_idx] <= merged;
    if (start) begin
      rd_word   <= mem[idx];
      lat_idx   <= idx;
      lat_off   <= bus.addr[1:0];
      lat_mode  <= bus.Mode;
      lat_sext  <= bus.Signext2;
      lat_load  <= req_load;
      lat_wdata <= bus.wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  data_mem_if bus ();

  data_mem_unit #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request at a falling edge, count stall cycles, and
  // return rdata / misalign at the first falling edge with stall low.
  // When keep is 0 the request lines are cleared one cycle later.
  task automatic issue(input logic mtr, input logic mw, input logic [1:0] mode,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic keep, output int stalls,
                       output logic [31:0] rd, output logic mis);
    @(negedge clk);
    bus.Memtoreg = mtr;
    bus.Memwrite = mw;
    bus.Mode     = mode;
    bus.Signext2 = sx;
    bus.addr     = a;
    bus.wdata    = wd;
    #1;
    mis    = bus.misalign;
    stalls = 0;
    while (bus.stall === 1'b1 && stalls < 10) begin
      stalls++;
      @(negedge clk);
    end
    rd = bus.rdata;
    if (!keep) begin
      @(negedge clk);
      bus.Memtoreg = 1'b0;
      bus.Memwrite = 1'b0;
    end
  endtask

  task automatic store_word(input logic [31:0] a, input logic [31:0] wd);
    int s; logic [31:0] r; logic m;
    issue(1'b0, 1'b1, 2'b10, 1'b0, a, wd, 1'b0, s, r, m);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (bus.rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'd0); end
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_store_load;
    int s; logic [31:0] r; logic m;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0, s, r, m);
    checks++;
    if (s !== 0) begin failures++; $display("FAIL word_store_stalls got=%0d exp=0", s); end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, s, r, m);
    checks++;
    if (s !== 2) begin failures++; $display("FAIL word_load_stalls got=%0d exp=2", s); end
    checks++;
    if (r !== 32'h12345678) begin failures++; $display("FAIL word_load_data got=%h exp=%h", r, 32'h12345678); end
  endtask

  task automatic test_sub_word_load;
    logic [31:0] exp_s [4];
    int s; logic [31:0] r; logic m;
    exp_s[0] = 32'h00000001; exp_s[1] = 32'h0000007F;
    exp_s[2] = 32'hFFFFFFFF; exp_s[3] = 32'hFFFFFF80;
    store_word(32'h40, 32'h80FF7F01);
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h40 + k, 32'h0, 1'b0, s, r, m);
      checks++;
      if (r !== exp_s[k]) begin failures++; $display("FAIL sbyte_off%0d got=%h exp=%h", k, r, exp_s[k]); end
    end
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'h00000080) begin failures++; $display("FAIL ubyte_off3 got=%h exp=%h", r, 32'h80); end
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'hFFFF80FF) begin failures++; $display("FAIL shalf_hi got=%h exp=%h", r, 32'hFFFF80FF); end
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'h00007F01) begin failures++; $display("FAIL uhalf_lo got=%h exp=%h", r, 32'h00007F01); end
    issue(1'b1, 1'b0, 2'b11, 1'b1, 32'h40, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'h80FF7F01) begin failures++; $display("FAIL mode3_word got=%h exp=%h", r, 32'h80FF7F01); end
  endtask

  task automatic test_half_store;
    int s; logic [31:0] r; logic m;
    store_word(32'h20, 32'hAABBCCDD);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 1'b0, s, r, m);
    checks++;
    if (s !== 2) begin failures++; $display("FAIL half_store_stalls got=%0d exp=2", s); end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'h1234CCDD) begin failures++; $display("FAIL half_store_word got=%h exp=%h", r, 32'h1234CCDD); end
  endtask

  task automatic test_byte_store;
    int s; logic [31:0] r; logic m;
    store_word(32'h20, 32'hAABBCCDD);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF55, 1'b0, s, r, m);
    checks++;
    if (s !== 2) begin failures++; $display("FAIL byte_store_stalls got=%0d exp=2", s); end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'hAABB55DD) begin failures++; $display("FAIL byte_store_word got=%h exp=%h", r, 32'hAABB55DD); end
  endtask

  task automatic test_misalign;
    int s; logic [31:0] r; logic m;
    // rdata currently holds 0xAABB55DD from the previous load
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 1'b0, s, r, m);
    checks++;
    if (m !== 1'b1) begin failures++; $display("FAIL mis_half_flag got=%b exp=1", m); end
    checks++;
    if (s !== 0) begin failures++; $display("FAIL mis_half_stalls got=%0d exp=0", s); end
    checks++;
    if (r !== 32'hAABB55DD) begin failures++; $display("FAIL mis_half_rdata got=%h exp=%h", r, 32'hAABB55DD); end
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hDEADBEEF, 1'b0, s, r, m);
    checks++;
    if (m !== 1'b1) begin failures++; $display("FAIL mis_word_flag got=%b exp=1", m); end
    checks++;
    if (s !== 0) begin failures++; $display("FAIL mis_word_stalls got=%0d exp=0", s); end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, s, r, m);
    checks++;
    if (m !== 1'b0) begin failures++; $display("FAIL aligned_flag got=%b exp=0", m); end
    checks++;
    if (r !== 32'hAABB55DD) begin failures++; $display("FAIL mis_word_mem got=%h exp=%h", r, 32'hAABB55DD); end
  endtask

  task automatic test_load_priority;
    int s; logic [31:0] r; logic m;
    // Both controls high: a load, the store data must not reach memory
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0BADF00D, 1'b0, s, r, m);
    checks++;
    if (r !== 32'hAABB55DD) begin failures++; $display("FAIL both_load_data got=%h exp=%h", r, 32'hAABB55DD); end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'hAABB55DD) begin failures++; $display("FAIL both_no_write got=%h exp=%h", r, 32'hAABB55DD); end
  endtask

  task automatic test_back_to_back;
    int s; logic [31:0] r; logic m;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, 1'b1, s, r, m);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0, s, r, m);
    checks++;
    if (s !== 2) begin failures++; $display("FAIL b2b_stalls got=%0d exp=2", s); end
    checks++;
    if (r !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_data got=%h exp=%h", r, 32'hCAFEF00D); end
  endtask

  task automatic test_reset_mid;
    int s; logic [31:0] r; logic m;
    @(negedge clk);
    bus.Memtoreg = 1'b0;
    bus.Memwrite = 1'b1;
    bus.Mode     = 2'b00;
    bus.Signext2 = 1'b0;
    bus.addr     = 32'h20;
    bus.wdata    = 32'h00000011;
    @(posedge clk);
    #2;
    checks++;
    if (dbg_state !== 2'd1) begin failures++; $display("FAIL mid_in_rdwait got=%0d exp=1", dbg_state); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", bus.stall); end
    checks++;
    if (bus.rdata !== 32'd0) begin failures++; $display("FAIL mid_rst_rdata got=%h exp=%h", bus.rdata, 32'd0); end
    @(posedge clk);
    @(negedge clk);
    bus.Memwrite = 1'b0;
    rst = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, s, r, m);
    checks++;
    if (r !== 32'hAABB55DD) begin failures++; $display("FAIL mid_rst_word got=%h exp=%h", r, 32'hAABB55DD); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.Memtoreg = 1'b0;
    bus.Memwrite = 1'b0;
    bus.Mode     = 2'b10;
    bus.Signext2 = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    test_reset();
    test_word_store_load();
    test_sub_word_load();
    test_half_store();
    test_byte_store();
    test_misalign();
    test_load_priority();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-memory access unit for the MIPS pipeline's MEM stage. It is the memory-side counterpart of the instruction decoder. It accepts the decoder's memory controls (`Memtoreg`, `Memwrite`, `Mode`, `Signext2`) plus a byte address and store data, and performs word, halfword and byte loads and stores against an internal word-wide synchronous RAM. Sub-word stores are done as read-modify-write. Loads and sub-word stores stall the pipeline until they complete.

## Interface
- `ADDR_WIDTH`, default 10: RAM word-address bits. Depth is 2^ADDR_WIDTH words of 32 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Memtoreg` input 1: load request.
- `Memwrite` input 1: store request.
- `Mode` input 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `Signext2` input 1: sign-extend a sub-word load when 1; zero-extend when 0.
- `addr` input 32: byte address. Word index is `addr[ADDR_WIDTH+1:2]`; upper bits are ignored.
- `wdata` input 32: store data. The byte or half is taken from the low bits.
- `rdata` output 32: load result, registered.
- `stall` output 1: pipeline must hold MEM-stage inputs stable.
- `misalign` output 1: combinational flag for an unaligned request in IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, DONE. Reset state is IDLE.
- Request in IDLE:
  - A request is active when `Memtoreg` or `Memwrite` is 1.
  - If both are 1, the access is treated as a load and `Memwrite` is ignored.
  - Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. A misaligned request gets `misalign`=1 and no RAM access, no stall, no state change, and `rdata` is unchanged.
- Word store, aligned: RAM word is written with `wdata` at the clock edge. No stall; stay in IDLE.
- Load, or byte/half store, aligned: RAM read is issued and the address, mode, extension and data are latched. `stall`=1; go to RD_WAIT.
- RD_WAIT: the RAM read word is available.
  - Load: extract the selected lane and extend it into `rdata`.
  - Sub-word store: merge the `wdata` low byte or half into the read word at the selected lane, then write the merged word back to the same index.
  - `stall`=1; go to DONE.
- DONE: `stall`=0, so the pipeline advances on this edge. `rdata` holds its value. Go to IDLE unconditionally; no new request is accepted in DONE.
- Lane selection is little-endian.
  - Byte lane k = `addr[1:0]` occupies bits 8k+7:8k.
  - Half lane = `addr[1]`; lane 0 is bits 15:0, lane 1 is bits 31:16.
- Extension: with `Signext2`=1 the upper bits copy the lane MSB; with `Signext2`=0 they are zero. Word loads return the full word.
- Inputs are ignored in RD_WAIT and DONE; the latched copies are used.
- Reset:
  - Any state goes to IDLE immediately; `rdata`=0, `stall`=0.
  - A pending sub-word merge is discarded; a reset asserted in RD_WAIT suppresses the write.
  - RAM contents are not reset.

## Timing
- Reset values: `rdata`=0, `stall`=0; `misalign` depends only on inputs.
- Aligned word store: 1 cycle, zero stall cycles.
- Load: request cycle (stall) → RD_WAIT (stall, `rdata` loads at the end of the cycle) → DONE (`rdata` valid, stall low). That is 2 stall cycles, and the result is visible 2 edges after the request edge.
- Sub-word store: 2 stall cycles; the merged write commits at the RD_WAIT→DONE edge.
- A load issued in the cycle right after a store sees the stored data; there is no RAM write-through hazard at the 1-cycle spacing.
- `stall` is combinational from the IDLE request decode and state; it is registered-only in RD_WAIT.

## Test plan
- Word store then word load:
  - Stimulus: store 0x12345678 at addr 0x10; load addr 0x10 with Mode=10.
  - Required: `stall` high for 2 cycles; `rdata`=0x12345678 in DONE.
- Signed byte load:
  - Stimulus: memory word 0x80FF7F01; load Mode=00, `Signext2`=1 at addr offsets 0, 1, 2, 3.
  - Required: `rdata` = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Repeat with `Signext2`=0 for offset 3; required `rdata`=0x00000080.
- Halfword store read-modify-write:
  - Stimulus: word 0xAABBCCDD at 0x20; store half 0x1234 at 0x22; word load of 0x20.
  - Required: 0x1234CCDD, with 2 stall cycles on the store.
- Byte store to offset 1, same word:
  - Stimulus: store wdata 0xFFFFFF55.
  - Required: word becomes 0xAABB55DD.
- Misalignment:
  - Stimulus: half load at 0x21; word store at 0x22.
  - Required: `misalign`=1, `stall`=0, memory and `rdata` unchanged.
- Reset mid-operation:
  - Stimulus: assert `rst` during RD_WAIT of a byte store.
  - Required: `stall`=0 and `rdata`=0 immediately; the target word is unmodified on readback.
